vex_bus_responder: RTL and testbench

//  Responder side of the VexRiscv simple iBus/dBus: accepts CPU fetch and load/store commands and

---
 rtl/soc_map_pkg.sv | 26 ++
 rtl/bus_prio_arb3.sv | 40 ++++
 rtl/vex_bus_responder.sv | 180 ++++++++++++++++++
 tb/tb_vex_bus_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_map_pkg.sv
// Shared SoC memory-map codes and bus-responder types.
// Region decode is used only when VEX_BUS_ERR_EN is defined.
package soc_map_pkg;

    localparam logic [1:0] RGN_RAM  = 2'b00;
    localparam logic [1:0] RGN_MMIO = 2'b01;
    localparam logic [1:0] RGN_ROM  = 2'b10;
    localparam logic [1:0] RGN_NONE = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StWrDone
    } bus_state_e;

    typedef enum logic [1:0] {
        SRC_DBG,
        SRC_D,
        SRC_I
    } bus_src_e;

    function automatic logic [1:0] region_of(input logic [31:0] adr);
        return adr[17:16];
    endfunction

endpackage

// File: rtl/bus_prio_arb3.sv
// Fixed-priority three-way arbiter (dbg > dBus > iBus) with a registered copy of the
// source id of the last grant, used to route the read response.
module bus_prio_arb3
    import soc_map_pkg::*;
(
    input  logic     clk_i,
    input  logic     reset_i,
    input  logic     en_i,
    input  logic     req_dbg_i,
    input  logic     req_d_i,
    input  logic     req_i_i,
    output logic     gnt_o,
    output bus_src_e src_o,
    output bus_src_e src_q_o
);

    bus_src_e src_q;

    always_comb begin
        gnt_o = en_i & (req_dbg_i | req_d_i | req_i_i);
        if (req_dbg_i) begin
            src_o = SRC_DBG;
        end else if (req_d_i) begin
            src_o = SRC_D;
        end else begin
            src_o = SRC_I;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            src_q <= SRC_DBG;
        end else if (gnt_o) begin
            src_q <= src_o;
        end
    end

    assign src_q_o = src_q;

endmodule

// File: rtl/vex_bus_responder.sv
// VexRiscv iBus/dBus + dbgu32 responder onto the single SoC memory bus.
// Optional: define VEX_BUS_ERR_EN to flag CPU accesses to unmapped space / ROM writes.
module vex_bus_responder
    import soc_map_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_run,
    input  logic        ibus_cmd_valid,
    input  logic [31:0] ibus_cmd_pc,
    output logic        ibus_cmd_ready,
    output logic        ibus_rsp_valid,
    output logic        ibus_rsp_error,
    output logic [31:0] ibus_rsp_inst,
    input  logic        dbus_cmd_valid,
    input  logic        dbus_cmd_wr,
    input  logic [3:0]  dbus_cmd_mask,
    input  logic [31:0] dbus_cmd_adr,
    input  logic [31:0] dbus_cmd_data,
    output logic        dbus_cmd_ready,
    output logic        dbus_rsp_ready,
    output logic        dbus_rsp_error,
    output logic [31:0] dbus_rsp_data,
    input  logic        dbg_mem_op,
    input  logic        dbg_rw,
    input  logic [31:0] dbg_adr,
    input  logic [31:0] dbg_do,
    output logic        dbg_mem_rdy,
    output logic [31:0] dbg_di,
    output logic        mem_op,
    output logic [31:0] mem_adr,
    output logic [3:0]  mem_wren,
    output logic [31:0] mem_di,
    input  logic [31:0] mem_do
);

    localparam logic [1:0] LatInit = 2'(MEM_LAT - 1);

    bus_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        dbg_seen_q, dbg_seen_d;
    logic [31:0] inst_q, ddata_q, dbgdi_q;

    logic        rsp_fire, free, grant, grant_bus, err_now, dbg_rd_rdy;
    logic        req_dbg, req_d, req_i;
    bus_src_e    gnt_src, src_q;
    logic [31:0] win_adr, win_di, rd_data;
    logic [3:0]  win_wren;
    logic        win_wr;

    // The response cycle of a read is also a free slot, allowing back-to-back grants.
    assign rsp_fire = (state_q == StRdWait) && (cnt_q == 2'd0) && !reset;
    assign free     = !reset && ((state_q == StIdle) || rsp_fire);

    assign req_dbg = dbg_mem_op & ~dbg_seen_q;
    assign req_d   = cpu_run & dbus_cmd_valid;
    assign req_i   = cpu_run & ibus_cmd_valid;

    bus_prio_arb3 u_arb (
        .clk_i    (clk),
        .reset_i  (reset),
        .en_i     (free),
        .req_dbg_i(req_dbg),
        .req_d_i  (req_d),
        .req_i_i  (req_i),
        .gnt_o    (grant),
        .src_o    (gnt_src),
        .src_q_o  (src_q)
    );

    always_comb begin
        win_adr  = ibus_cmd_pc;
        win_wr   = 1'b0;
        win_wren = 4'b0000;
        win_di   = 32'h0;
        case (gnt_src)
            SRC_DBG: begin
                win_adr  = dbg_adr;
                win_wr   = ~dbg_rw;
                win_wren = {4{~dbg_rw}};
                win_di   = dbg_do;
            end
            SRC_D: begin
                win_adr  = dbus_cmd_adr;
                win_wr   = dbus_cmd_wr;
                win_wren = dbus_cmd_wr ? dbus_cmd_mask : 4'b0000;
                win_di   = dbus_cmd_data;
            end
            default: begin
                win_adr  = ibus_cmd_pc;
            end
        endcase
    end

`ifdef VEX_BUS_ERR_EN
    // dbgu32 must be able to load ROM, so only CPU accesses are decoded.
    assign err_now = (gnt_src != SRC_DBG) &&
                     ((region_of(win_adr) == RGN_NONE) ||
                      (win_wr && (region_of(win_adr) == RGN_ROM)));
`else
    assign err_now = 1'b0;
`endif

    assign grant_bus = grant & ~err_now;
    assign mem_op    = grant_bus;
    assign mem_adr   = grant_bus ? win_adr : 32'h0;
    assign mem_wren  = grant_bus ? win_wren : 4'b0000;
    assign mem_di    = grant_bus ? win_di : 32'h0;

    assign ibus_cmd_ready = grant && (gnt_src == SRC_I);
    assign dbus_cmd_ready = grant && (gnt_src == SRC_D);

    assign rd_data    = err_q ? 32'h0 : mem_do;
    assign dbg_rd_rdy = rsp_fire && (src_q == SRC_DBG);

    assign ibus_rsp_valid = rsp_fire && (src_q == SRC_I);
    assign ibus_rsp_error = ibus_rsp_valid & err_q;
    assign ibus_rsp_inst  = ibus_rsp_valid ? rd_data : inst_q;

    assign dbus_rsp_ready = rsp_fire && (src_q == SRC_D);
    assign dbus_rsp_error = dbus_rsp_ready & err_q;
    assign dbus_rsp_data  = dbus_rsp_ready ? rd_data : ddata_q;

    assign dbg_mem_rdy = dbg_rd_rdy || ((state_q == StWrDone) && !reset);
    assign dbg_di      = dbg_rd_rdy ? rd_data : dbgdi_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        dbg_seen_d = dbg_mem_op & (dbg_seen_q | (grant && (gnt_src == SRC_DBG)));
        case (state_q)
            StIdle: ;
            StRdWait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StWrDone: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (grant) begin
            if (!win_wr) begin
                state_d = StRdWait;
                cnt_d   = LatInit;
                err_d   = err_now;
            end else if (gnt_src == SRC_DBG) begin
                state_d = StWrDone;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            err_q      <= 1'b0;
            dbg_seen_q <= 1'b0;
            inst_q     <= 32'h0;
            ddata_q    <= 32'h0;
            dbgdi_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            dbg_seen_q <= dbg_seen_d;
            inst_q     <= ibus_rsp_inst;
            ddata_q    <= dbus_rsp_data;
            dbgdi_q    <= dbg_di;
        end
    end

endmodule

// File: tb/tb_vex_bus_responder.sv
// Directed bench for vex_bus_responder: one instance with MEM_LAT=1, one with MEM_LAT=3.
// Memory model returns address+3 one cycle after each bus cycle and holds it.
module tb_vex_bus_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_run = 1'b0;
    logic        ibus_cmd_valid = 1'b0, ibus_cmd_valid3 = 1'b0;
    logic [31:0] ibus_cmd_pc = 32'h0;
    logic        dbus_cmd_valid = 1'b0, dbus_cmd_wr = 1'b0;
    logic [3:0]  dbus_cmd_mask = 4'h0;
    logic [31:0] dbus_cmd_adr = 32'h0, dbus_cmd_data = 32'h0;
    logic        dbg_mem_op = 1'b0, dbg_rw = 1'b0;
    logic [31:0] dbg_adr = 32'h0, dbg_do = 32'h0;
    logic [31:0] mem_do1 = 32'h0, mem_do3 = 32'h0;

    logic        ibus_cmd_ready1, ibus_rsp_valid1, ibus_rsp_error1;
    logic [31:0] ibus_rsp_inst1;
    logic        dbus_cmd_ready1, dbus_rsp_ready1, dbus_rsp_error1;
    logic [31:0] dbus_rsp_data1;
    logic        dbg_mem_rdy1;
    logic [31:0] dbg_di1;
    logic        mem_op1;
    logic [31:0] mem_adr1, mem_di1;
    logic [3:0]  mem_wren1;

    logic        ibus_cmd_ready3, ibus_rsp_valid3, ibus_rsp_error3;
    logic [31:0] ibus_rsp_inst3;
    logic        dbus_cmd_ready3, dbus_rsp_ready3, dbus_rsp_error3;
    logic [31:0] dbus_rsp_data3;
    logic        dbg_mem_rdy3;
    logic [31:0] dbg_di3;
    logic        mem_op3;
    logic [31:0] mem_adr3, mem_di3;
    logic [3:0]  mem_wren3;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_op1) mem_do1 <= mem_adr1 + 32'd3;
        if (mem_op3) mem_do3 <= mem_adr3 + 32'd3;
    end

    vex_bus_responder #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .cpu_run(cpu_run),
        .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_pc(ibus_cmd_pc),
        .ibus_cmd_ready(ibus_cmd_ready1), .ibus_rsp_valid(ibus_rsp_valid1),
        .ibus_rsp_error(ibus_rsp_error1), .ibus_rsp_inst(ibus_rsp_inst1),
        .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_wr(dbus_cmd_wr),
        .dbus_cmd_mask(dbus_cmd_mask), .dbus_cmd_adr(dbus_cmd_adr),
        .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_ready(dbus_cmd_ready1),
        .dbus_rsp_ready(dbus_rsp_ready1), .dbus_rsp_error(dbus_rsp_error1),
        .dbus_rsp_data(dbus_rsp_data1),
        .dbg_mem_op(dbg_mem_op), .dbg_rw(dbg_rw), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
        .dbg_mem_rdy(dbg_mem_rdy1), .dbg_di(dbg_di1),
        .mem_op(mem_op1), .mem_adr(mem_adr1), .mem_wren(mem_wren1), .mem_di(mem_di1),
        .mem_do(mem_do1)
    );

    vex_bus_responder #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .cpu_run(cpu_run),
        .ibus_cmd_valid(ibus_cmd_valid3), .ibus_cmd_pc(ibus_cmd_pc),
        .ibus_cmd_ready(ibus_cmd_ready3), .ibus_rsp_valid(ibus_rsp_valid3),
        .ibus_rsp_error(ibus_rsp_error3), .ibus_rsp_inst(ibus_rsp_inst3),
        .dbus_cmd_valid(1'b0), .dbus_cmd_wr(1'b0),
        .dbus_cmd_mask(4'h0), .dbus_cmd_adr(32'h0),
        .dbus_cmd_data(32'h0), .dbus_cmd_ready(dbus_cmd_ready3),
        .dbus_rsp_ready(dbus_rsp_ready3), .dbus_rsp_error(dbus_rsp_error3),
        .dbus_rsp_data(dbus_rsp_data3),
        .dbg_mem_op(1'b0), .dbg_rw(1'b0), .dbg_adr(32'h0), .dbg_do(32'h0),
        .dbg_mem_rdy(dbg_mem_rdy3), .dbg_di(dbg_di3),
        .mem_op(mem_op3), .mem_adr(mem_adr3), .mem_wren(mem_wren3), .mem_di(mem_di3),
        .mem_do(mem_do3)
    );

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        step();
        ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h10; dbg_mem_op = 1'b1; dbg_rw = 1'b1;
        #1;
        checks++;
        if ({mem_op1, ibus_cmd_ready1, dbus_cmd_ready1, ibus_rsp_valid1, dbus_rsp_ready1,
             dbg_mem_rdy1, ibus_rsp_error1, dbus_rsp_error1} !== 8'h00)
            $display("FAIL reset_ctrl1 got=%b exp=0", {mem_op1, ibus_cmd_ready1,
                     dbus_cmd_ready1, ibus_rsp_valid1, dbus_rsp_ready1, dbg_mem_rdy1});
        else passed++;
        checks++;
        if ({mem_adr1, mem_wren1, mem_di1, ibus_rsp_inst1, dbus_rsp_data1, dbg_di1} !== '0)
            $display("FAIL reset_data1 got adr=%h wren=%b di=%h exp=0", mem_adr1, mem_wren1,
                     mem_di1);
        else passed++;
        checks++;
        if ({mem_op3, ibus_cmd_ready3, ibus_rsp_valid3, ibus_rsp_inst3} !== '0)
            $display("FAIL reset_dut3 got op=%b rdy=%b inst=%h exp=0", mem_op3,
                     ibus_cmd_ready3, ibus_rsp_inst3);
        else passed++;
        step();
        ibus_cmd_valid = 1'b0; dbg_mem_op = 1'b0; dbg_rw = 1'b0;
        step();
        reset = 1'b0; cpu_run = 1'b1;
    endtask

    task automatic test_ifetch;
        step();
        ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h10;
        #1;
        checks++;
        if ({ibus_cmd_ready1, mem_op1, mem_adr1, mem_wren1} !== {1'b1, 1'b1, 32'h10, 4'h0})
            $display("FAIL ifetch_cmd got rdy=%b op=%b adr=%h wren=%b exp 1 1 10 0",
                     ibus_cmd_ready1, mem_op1, mem_adr1, mem_wren1);
        else passed++;
        step();
        ibus_cmd_valid = 1'b0;
        #1;
        checks++;
        if ({ibus_rsp_valid1, ibus_rsp_error1, ibus_rsp_inst1} !== {1'b1, 1'b0, 32'h13})
            $display("FAIL ifetch_rsp got v=%b e=%b inst=%h exp 1 0 13", ibus_rsp_valid1,
                     ibus_rsp_error1, ibus_rsp_inst1);
        else passed++;
        step();
        #1;
        checks++;
        if ({ibus_rsp_valid1, ibus_rsp_inst1} !== {1'b0, 32'h13})
            $display("FAIL ifetch_hold got v=%b inst=%h exp 0 13", ibus_rsp_valid1,
                     ibus_rsp_inst1);
        else passed++;
    endtask

    task automatic test_priority;
        step();
        dbg_mem_op = 1'b1; dbg_rw = 1'b1; dbg_adr = 32'h20000;
        dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_adr = 32'h10018;
        ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h40;
        #1;
        checks++;
        if ({mem_op1, mem_adr1, dbus_cmd_ready1, ibus_cmd_ready1} !== {1'b1, 32'h20000, 2'b00})
            $display("FAIL prio_c0 got op=%b adr=%h drdy=%b irdy=%b exp 1 20000 0 0",
                     mem_op1, mem_adr1, dbus_cmd_ready1, ibus_cmd_ready1);
        else passed++;
        step();
        #1;
        checks++;
        if ({dbg_mem_rdy1, dbg_di1, dbus_cmd_ready1, ibus_cmd_ready1, mem_adr1} !==
            {1'b1, 32'h20003, 2'b10, 32'h10018})
            $display("FAIL prio_c1 got rdy=%b di=%h drdy=%b irdy=%b adr=%h exp 1 20003 1 0 10018",
                     dbg_mem_rdy1, dbg_di1, dbus_cmd_ready1, ibus_cmd_ready1, mem_adr1);
        else passed++;
        step();
        dbus_cmd_valid = 1'b0; dbg_mem_op = 1'b0;
        #1;
        checks++;
        if ({dbus_rsp_ready1, dbus_rsp_data1, ibus_cmd_ready1, mem_adr1, dbg_mem_rdy1, dbg_di1}
            !== {1'b1, 32'h1001B, 1'b1, 32'h40, 1'b0, 32'h20003})
            $display("FAIL prio_c2 got drsp=%b data=%h irdy=%b adr=%h dbgrdy=%b exp 1 1001b 1 40 0",
                     dbus_rsp_ready1, dbus_rsp_data1, ibus_cmd_ready1, mem_adr1, dbg_mem_rdy1);
        else passed++;
        step();
        ibus_cmd_valid = 1'b0;
        #1;
        checks++;
        if ({ibus_rsp_valid1, ibus_rsp_inst1, dbus_rsp_ready1, dbg_mem_rdy1, dbus_rsp_data1}
            !== {1'b1, 32'h43, 2'b00, 32'h1001B})
            $display("FAIL prio_c3 got irsp=%b inst=%h drsp=%b dbgrdy=%b exp 1 43 0 0",
                     ibus_rsp_valid1, ibus_rsp_inst1, dbus_rsp_ready1, dbg_mem_rdy1);
        else passed++;
        step();
        #1;
        checks++;
        if ({ibus_rsp_valid1, dbus_rsp_ready1, dbg_mem_rdy1, mem_op1} !== 4'b0000)
            $display("FAIL prio_c4 got %b exp 0000", {ibus_rsp_valid1, dbus_rsp_ready1,
                     dbg_mem_rdy1, mem_op1});
        else passed++;
    endtask

    task automatic test_store;
        step();
        dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b1; dbus_cmd_mask = 4'b0011;
        dbus_cmd_adr = 32'h4; dbus_cmd_data = 32'hDEADBEEF;
        #1;
        checks++;
        if ({mem_op1, dbus_cmd_ready1, mem_wren1, mem_adr1, mem_di1} !==
            {2'b11, 4'b0011, 32'h4, 32'hDEADBEEF})
            $display("FAIL store_cmd got op=%b rdy=%b wren=%b adr=%h di=%h exp 1 1 0011 4 deadbeef",
                     mem_op1, dbus_cmd_ready1, mem_wren1, mem_adr1, mem_di1);
        else passed++;
        step();
        dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0; dbus_cmd_mask = 4'h0;
        #1;
        checks++;
        if ({mem_op1, mem_wren1, dbus_rsp_ready1, dbus_cmd_ready1} !== 7'b0)
            $display("FAIL store_after got op=%b wren=%b rsp=%b exp 0", mem_op1, mem_wren1,
                     dbus_rsp_ready1);
        else passed++;
        step();
        #1;
        checks++;
        if (dbus_rsp_ready1 !== 1'b0)
            $display("FAIL store_norsp got=%b exp=0", dbus_rsp_ready1);
        else passed++;
    endtask

    task automatic test_cpu_run;
        logic seen = 1'b0;
        cpu_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h80;
            #1;
            if (ibus_cmd_ready1 || mem_op1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL halt_noready got=%b exp=0", seen);
        else passed++;
        step();
        cpu_run = 1'b1;
        #1;
        checks++;
        if ({ibus_cmd_ready1, mem_adr1} !== {1'b1, 32'h80})
            $display("FAIL run_grant got rdy=%b adr=%h exp 1 80", ibus_cmd_ready1, mem_adr1);
        else passed++;
        step();
        ibus_cmd_valid = 1'b0;
        #1;
        checks++;
        if ({ibus_rsp_valid1, ibus_rsp_inst1} !== {1'b1, 32'h83})
            $display("FAIL run_rsp got v=%b inst=%h exp 1 83", ibus_rsp_valid1, ibus_rsp_inst1);
        else passed++;
    endtask

    task automatic test_dbg_write;
        step();
        dbg_mem_op = 1'b1; dbg_rw = 1'b0; dbg_adr = 32'h100; dbg_do = 32'h55;
        #1;
        checks++;
        if ({mem_op1, mem_wren1, mem_di1, dbg_mem_rdy1} !== {1'b1, 4'hF, 32'h55, 1'b0})
            $display("FAIL dbgwr_cmd got op=%b wren=%b di=%h rdy=%b exp 1 1111 55 0",
                     mem_op1, mem_wren1, mem_di1, dbg_mem_rdy1);
        else passed++;
        step();
        #1;
        checks++;
        if ({dbg_mem_rdy1, mem_op1} !== 2'b10)
            $display("FAIL dbgwr_rdy got rdy=%b op=%b exp 1 0", dbg_mem_rdy1, mem_op1);
        else passed++;
        step();
        #1;
        checks++;
        if ({dbg_mem_rdy1, mem_op1} !== 2'b00)
            $display("FAIL dbg_noregrant got rdy=%b op=%b exp 0 0", dbg_mem_rdy1, mem_op1);
        else passed++;
        step();
        dbg_mem_op = 1'b0;
        step();
        dbg_mem_op = 1'b1; dbg_rw = 1'b1; dbg_adr = 32'h20000;
        #1;
        checks++;
        if ({mem_op1, mem_wren1, mem_adr1} !== {1'b1, 4'h0, 32'h20000})
            $display("FAIL dbg_regrant got op=%b wren=%b adr=%h exp 1 0 20000", mem_op1,
                     mem_wren1, mem_adr1);
        else passed++;
        step();
        dbg_mem_op = 1'b0;
        #1;
        checks++;
        if ({dbg_mem_rdy1, dbg_di1} !== {1'b1, 32'h20003})
            $display("FAIL dbgrd_rsp got rdy=%b di=%h exp 1 20003", dbg_mem_rdy1, dbg_di1);
        else passed++;
    endtask

    task automatic test_lat3_reset;
        logic seen = 1'b0;
        step();
        ibus_cmd_valid3 = 1'b1; ibus_cmd_pc = 32'h300;
        #1;
        checks++;
        if ({ibus_cmd_ready3, mem_op3} !== 2'b11)
            $display("FAIL lat3_cmd got rdy=%b op=%b exp 1 1", ibus_cmd_ready3, mem_op3);
        else passed++;
        for (int i = 1; i <= 4; i++) begin
            step();
            ibus_cmd_valid3 = 1'b0;
            #1;
            checks++;
            if (ibus_rsp_valid3 !== (i == 3))
                $display("FAIL lat3_rsp_c%0d got=%b exp=%b", i, ibus_rsp_valid3, (i == 3));
            else passed++;
        end
        checks++;
        if (ibus_rsp_inst3 !== 32'h303)
            $display("FAIL lat3_inst got=%h exp=303", ibus_rsp_inst3);
        else passed++;
        step();
        ibus_cmd_valid3 = 1'b1; ibus_cmd_pc = 32'h400;
        step();
        ibus_cmd_valid3 = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_op3, ibus_rsp_valid3, ibus_cmd_ready3, ibus_rsp_inst3} !== '0)
            $display("FAIL lat3_midreset got op=%b v=%b inst=%h exp 0", mem_op3,
                     ibus_rsp_valid3, ibus_rsp_inst3);
        else passed++;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ibus_rsp_valid3 || mem_op3) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL lat3_dropped got=%b exp=0", seen);
        else passed++;
    endtask

    task automatic test_bus_err;
        step();
        dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_adr = 32'h30000;
        #1;
`ifdef VEX_BUS_ERR_EN
        checks++;
        if ({dbus_cmd_ready1, mem_op1} !== 2'b10)
            $display("FAIL err_cmd got rdy=%b op=%b exp 1 0", dbus_cmd_ready1, mem_op1);
        else passed++;
        step();
        dbus_cmd_valid = 1'b0;
        #1;
        checks++;
        if ({dbus_rsp_ready1, dbus_rsp_error1, dbus_rsp_data1} !== {2'b11, 32'h0})
            $display("FAIL err_rsp got v=%b e=%b data=%h exp 1 1 0", dbus_rsp_ready1,
                     dbus_rsp_error1, dbus_rsp_data1);
        else passed++;
`else
        checks++;
        if ({dbus_cmd_ready1, mem_op1, mem_adr1} !== {2'b11, 32'h30000})
            $display("FAIL noerr_cmd got rdy=%b op=%b adr=%h exp 1 1 30000", dbus_cmd_ready1,
                     mem_op1, mem_adr1);
        else passed++;
        step();
        dbus_cmd_valid = 1'b0;
        #1;
        checks++;
        if ({dbus_rsp_ready1, dbus_rsp_error1, dbus_rsp_data1} !== {2'b10, 32'h30003})
            $display("FAIL noerr_rsp got v=%b e=%b data=%h exp 1 0 30003", dbus_rsp_ready1,
                     dbus_rsp_error1, dbus_rsp_data1);
        else passed++;
`endif
        step();
        dbg_mem_op = 1'b1; dbg_rw = 1'b1; dbg_adr = 32'h30000;
        #1;
        checks++;
        if ({mem_op1, mem_adr1} !== {1'b1, 32'h30000})
            $display("FAIL dbg_rgn3_cmd got op=%b adr=%h exp 1 30000", mem_op1, mem_adr1);
        else passed++;
        step();
        dbg_mem_op = 1'b0;
        #1;
        checks++;
        if ({dbg_mem_rdy1, dbg_di1} !== {1'b1, 32'h30003})
            $display("FAIL dbg_rgn3_rsp got rdy=%b di=%h exp 1 30003", dbg_mem_rdy1, dbg_di1);
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_priority();
        test_store();
        test_cpu_run();
        test_dbg_write();
        test_lat3_reset();
        test_bus_err();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
